// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : des_key_schedule
//  Description : Sequential DES key-schedule generator. Applies PC-1 to a
//                64-bit key, then produces one 48-bit subkey per clock by
//                left-rotating the C/D halves and applying PC-2. The 16
//                subkeys land in a register bank in encrypt order, or in
//                reversed order for decryption.
//  Ports       : clk        - system clock, rising edge
//                n_rst      - asynchronous active-low reset
//                key_in     - 64-bit key, index 0 = FIPS-46 bit 1 (MSB)
//                key_load   - one-cycle strobe, captures key_in/decrypt
//                decrypt    - 1 = store subkeys in reversed order
//                round_keys - registered subkey bank, entry i feeds round i
//                keys_valid - bank complete and stable for last loaded key
//                busy       - generation in progress
//                parity_err - key byte odd-parity violation (advisory)
//  Options     : DES_KEY_PARITY_CHECK_EN - when defined, each key byte is
//                checked for odd parity on key_load; otherwise parity_err
//                is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module des_key_schedule #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic [0:63]                 key_in,
    input  logic                        key_load,
    input  logic                        decrypt,
    output logic [0:NUM_ROUNDS-1][0:47] round_keys,
    output logic                        keys_valid,
    output logic                        busy,
    output logic                        parity_err
);

    localparam int CNT_W = $clog2(NUM_ROUNDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ROUNDS - 1);

    // FIPS-46 tables, 1-based bit numbers as published.
    localparam int PC1_TBL [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_TBL [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_next;
    logic                          w_load;
    logic [0:27]                   r_c;
    logic [0:27]                   r_d;
    logic [CNT_W-1:0]              r_cnt;
    logic                          r_dec;
    logic [0:NUM_ROUNDS-1][0:47]   r_round_keys;
    logic [0:55]                   w_pc1;
    logic [0:27]                   w_c_rot;
    logic [0:27]                   w_d_rot;
    logic [0:55]                   w_cd;
    logic [0:47]                   w_subkey;
    logic                          w_shift_one;
    logic [CNT_W-1:0]              w_idx;

    // Pure wiring permutations.
    for (genvar j = 0; j < 56; j++) begin : g_pc1
        assign w_pc1[j] = key_in[PC1_TBL[j] - 1];
    end

    for (genvar j = 0; j < 48; j++) begin : g_pc2
        assign w_subkey[j] = w_cd[PC2_TBL[j] - 1];
    end

    // Rounds 1, 2, 9 and 16 rotate by one; all others by two.
    assign w_shift_one = (r_cnt == CNT_W'(0)) || (r_cnt == CNT_W'(1)) ||
                         (r_cnt == CNT_W'(8)) || (r_cnt == LAST);
    assign w_c_rot = w_shift_one ? {r_c[1:27], r_c[0]} : {r_c[2:27], r_c[0:1]};
    assign w_d_rot = w_shift_one ? {r_d[1:27], r_d[0]} : {r_d[2:27], r_d[0:1]};
    assign w_cd    = {w_c_rot, w_d_rot};

    // Decrypt order is simply the encrypt bank mirrored.
    assign w_idx = r_dec ? (LAST - r_cnt) : r_cnt;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        busy         = 1'b0;
        keys_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (key_load) begin
                    w_load       = 1'b1;
                    w_state_next = S_GEN;
                end
            end
            S_GEN: begin
                busy = 1'b1;
                if (r_cnt == LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                keys_valid = 1'b1;
                if (key_load) begin
                    w_load       = 1'b1;
                    w_state_next = S_GEN;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_c          <= '0;
            r_d          <= '0;
            r_cnt        <= '0;
            r_dec        <= 1'b0;
            r_round_keys <= '0;
        end else if (w_load) begin
            r_c   <= w_pc1[0:27];
            r_d   <= w_pc1[28:55];
            r_dec <= decrypt;
            r_cnt <= '0;
        end else if (r_state == S_GEN) begin
            r_c                 <= w_c_rot;
            r_d                 <= w_d_rot;
            r_round_keys[w_idx] <= w_subkey;
            r_cnt               <= r_cnt + CNT_W'(1);
        end
    end

    assign round_keys = r_round_keys;

    // The parity bits never reach the key schedule itself.
    logic w_unused_parity_bits;
    assign w_unused_parity_bits = ^{key_in[7], key_in[15], key_in[23], key_in[31],
                                    key_in[39], key_in[47], key_in[55], key_in[63]};

`ifdef DES_KEY_PARITY_CHECK_EN
    logic [7:0] w_byte_odd;
    logic       r_parity_err;

    for (genvar b = 0; b < 8; b++) begin : g_parity
        assign w_byte_odd[b] = ^key_in[8*b +: 8];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_parity_err <= 1'b0;
        end else if (w_load) begin
            r_parity_err <= ~(&w_byte_odd);
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Sequential DES key-schedule generator. Sits directly upstream of the 16-round DES datapath and drives its round_keys[0:15][0:47] bus.
- Expands a 64-bit key into 16 48-bit subkeys, one per clock, via PC-1, per-round left rotations of C/D and PC-2.
- Stores the subkeys in a register bank, in encrypt or decrypt order. A 3DES wrapper instantiates one per DES stage.

Parameters:
NUM_ROUNDS, 16, number of subkeys generated; fixed at 16 for DES, exists only for counter sizing.

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
key_in  input  [0:63]  DES key; bit 0 = FIPS-46 bit 1 (MSB); parity bits 7,15,...,63 dropped by PC-1
key_load  input  1  one-cycle strobe; capture key_in and start generation
decrypt  input  1  sampled with key_load; 1 = store subkeys in reversed order
round_keys  output  [0:15][0:47]  registered subkey bank; index i feeds DES round i
keys_valid  output  1  bank complete and stable for the key last loaded
busy  output  1  generation in progress
parity_err  output  1  key byte odd-parity violation (see Optional Feature)

Behaviour:
- Reset (n_rst low, async):
  - FSM to IDLE.
  - round_keys all 0; keys_valid=0; busy=0; parity_err=0.
  - C/D registers and round counter cleared.
- FSM states: IDLE, GEN, DONE.
- IDLE/DONE with key_load=1 at edge T:
  - C0 <= PC1(key_in)[0:27], D0 <= PC1(key_in)[28:55].
  - dec_r <= decrypt; cnt <= 0.
  - keys_valid <= 0; busy <= 1; go to GEN.
- GEN, one round per edge:
  - Shift amount is 1 for cnt in {0,1,8,15}, else 2. Left-rotate each 28-bit half independently.
  - K = PC2({C', D'}).
  - Write K to round_keys[cnt] if dec_r=0, else to round_keys[15-cnt].
  - C <= C', D <= D', cnt <= cnt+1.
- Completion:
  - The edge with cnt=15 writes the last subkey.
  - Same edge: keys_valid <= 1, busy <= 0, go to DONE.
  - Latency: key_load sampled at edge T -> keys_valid high after edge T+16.
- Total rotation over 16 rounds is 28, so C/D return to C0/D0 at completion. A checker may assert this.
- key_load during GEN is ignored; generation continues undisturbed.
- key_load in DONE restarts generation:
  - keys_valid drops after the same edge.
  - Bank entries are overwritten progressively and are not guaranteed stable until keys_valid rises again.
- decrypt is only sampled with key_load; changes at other times have no effect.
- Reset mid-GEN: immediate return to IDLE with all outputs at reset values. No partial bank is retained.
- DONE holds round_keys and keys_valid indefinitely until key_load or reset.
- Permutation tables PC-1, PC-2 and the shift schedule follow FIPS-46 exactly. Both are pure bit-wiring with no arithmetic.

Optional Feature:
Macro DES_KEY_PARITY_CHECK_EN.
- Defined:
  - On key_load, each of the 8 key_in bytes is checked for odd parity.
  - parity_err is registered at edge T: 1 if any byte has even parity, else 0.
  - It holds until the next key_load or reset.
  - Generation proceeds regardless; the flag is advisory.
- Not defined: parity_err is tied to 0 and no parity logic is synthesized. The port remains present.

Test Plan:
- Reset, then key_in=64'h133457799BBCDFF1, decrypt=0, key_load pulse -> after 16 edges keys_valid=1, busy=0; round_keys[0]=48'h1B02EFFC7072, round_keys[15]=48'hCB3D8B0E17F5; parity_err=0.
- Same key with decrypt=1 -> round_keys[15]=48'h1B02EFFC7072, round_keys[0]=48'hCB3D8B0E17F5; full bank equals the encrypt bank reversed.
- Second key_load at cycle 5 of GEN -> ignored; bank and completion timing are identical to scenario 1. Then key_load in DONE with key 0 -> keys_valid falls next cycle and rises 16 edges later with all 16 subkeys = 0.
- Assert n_rst low at cycle 8 of GEN -> keys_valid=0, busy=0 and all round_keys=0 immediately (async). A new key_load after release completes normally in 16 edges.
- With DES_KEY_PARITY_CHECK_EN: key 64'h123457799BBCDFF1 (byte 0 = 0x12, even parity) -> parity_err=1 after the key_load edge; reload 64'h133457799BBCDFF1 -> parity_err=0. Without the macro, parity_err=0 for both keys.
